branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter PC_W, default 7, PC width in bits.
REQ-002 Parameter OFS_W, default 32, branch offset width in bits; OFS_W >= PC_W.
REQ-003 Parameter ENTRIES, default 8, buffer depth; power of two, 2..64; IDX_W = log2(ENTRIES) < PC_W.
REQ-004 Parameter SHIFT, default 0, left shift applied to offset (0 word-addressed, 2 byte-addressed).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 flush  in  1  invalidate all entries.
REQ-008 lk_valid  in  1  lookup request.
REQ-009 lk_pc  in  PC_W  fetch PC to look up.
REQ-010 lk_hit  out  1  registered; entry present for lk_pc.
REQ-011 lk_taken  out  1  registered; prediction (counter MSB), 0 on miss.
REQ-012 lk_target  out  PC_W  registered; stored target, 0 on miss.
REQ-013 rs_valid  in  1  branch resolve/update strobe.
REQ-014 rs_pc  in  PC_W  PC of resolved branch.
REQ-015 rs_pc_next  in  PC_W  PC following the branch.
REQ-016 rs_offset  in  OFS_W  signed branch offset.
REQ-017 rs_taken  in  1  actual outcome.
REQ-018 rs_target  out  PC_W  registered computed target.
REQ-019 rs_target_valid  out  1  one-cycle pulse qualifying rs_target.

Function
REQ-020 Target SHALL be rs_pc_next + ((rs_offset << SHIFT) truncated to PC_W), modulo 2^PC_W; no overflow flag, carry discarded.
REQ-021 rs_target/rs_target_valid SHALL appear exactly one cycle after rs_valid; rs_target holds its value when rs_target_valid=0.
REQ-022 Entry = valid, tag (rs_pc[PC_W-1:IDX_W]), target (PC_W), 2-bit saturating counter; index = pc[IDX_W-1:0].
REQ-023 Lookup: one-cycle latency; hit = valid AND tag match; lk_* outputs SHALL be 0 in the cycle after lk_valid=0.
REQ-024 Update on hit: taken -> counter+1 saturating at 11, target overwritten; not-taken -> counter-1 saturating at 00; entry stays valid.
REQ-025 Update on miss: taken -> allocate (valid=1, tag, target, counter=10), replacing any aliased entry; not-taken -> no change.
REQ-026 Lookup and update in same cycle, same index: lookup SHALL return pre-update contents (read-before-write).
REQ-027 flush SHALL clear all valid bits at the next edge; flush wins over a same-cycle update (update discarded, rs_target still produced); same-cycle lookup returns pre-flush contents.
REQ-028 Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

Reset
REQ-029 rst_n low SHALL immediately clear all valid bits, counters, tags, targets and every output to 0.
REQ-030 Reset asserted mid-update SHALL leave no partially written entry; first update honoured on the first edge after deassertion.

Structure
REQ-031 Package branch_pkg SHALL hold counter encoding constants (CNT_SNT, CNT_WNT, CNT_WT, CNT_ST) and the counter next-state function.
REQ-032 Target arithmetic SHALL be one sub-module, branch_target_adder (parametrised PC_W/OFS_W/SHIFT, combinational); storage and control remain in the top.
REQ-033 Storage SHALL be flip-flop arrays (no RAM macros), to permit async reset.

Verification (PC_W=7, ENTRIES=8, SHIFT=0)
REQ-034 Reset, lookup lk_pc=5 -> next cycle lk_hit=0, lk_taken=0, lk_target=0.
REQ-035 Resolve rs_pc=5, rs_pc_next=6, rs_offset=3, taken -> next cycle rs_target=9, rs_target_valid=1; then lookup 5 -> hit=1, taken=1, target=9.
REQ-036 Wrap: rs_pc_next=127, offset=1 -> rs_target=0; rs_pc_next=1, offset=32'hFFFF_FFFE -> rs_target=127.
REQ-037 Counter: allocate pc 5 (10), two not-taken -> lookup hit=1, taken=0; then four taken -> counter 11, fifth taken stays 11.
REQ-038 Alias: allocate pc 5, then taken update pc 13 (target 20) -> lookup 5 miss, lookup 13 hit target 20.
REQ-039 Same-cycle lookup+update pc 5 returns old entry; flush with rs_valid taken on pc 2 -> all lookups miss afterwards, rs_target_valid still pulses.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg
// Shared definitions for the branch target buffer: the 2-bit saturating
// direction counter encoding and its next-state function.
//   CNT_SNT/CNT_WNT/CNT_WT/CNT_ST : strong/weak not-taken, weak/strong taken
//   cnt_next(cnt, taken)          : saturating increment on taken,
//                                   saturating decrement on not-taken
package branch_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt == CNT_ST) nxt = CNT_ST;
      else               nxt = cnt + 2'b01;
    end else begin
      if (cnt == CNT_SNT) nxt = CNT_SNT;
      else                nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// branch_target_adder
// Combinational branch target computation: target = pc_next + (offset << SHIFT),
// with the shifted offset truncated to PC_W and the carry discarded, so the
// result wraps modulo 2^PC_W.
// Ports:
//   pc_next [PC_W]  : PC following the branch
//   offset  [OFS_W] : signed branch offset (only the low PC_W bits matter
//                     after shifting, so sign extension is implicit)
//   target  [PC_W]  : computed target
module branch_target_adder #(
  parameter int PC_W  = 7,
  parameter int OFS_W = 32,
  parameter int SHIFT = 0
) (
  input  logic [PC_W-1:0]  pc_next,
  input  logic [OFS_W-1:0] offset,
  output logic [PC_W-1:0]  target
);

  logic [OFS_W-1:0] shifted_s;

  // Shift in full offset width, then keep only the bits that can reach the PC.
  always_comb begin
    shifted_s = offset << SHIFT;
    target    = pc_next + shifted_s[PC_W-1:0];
  end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer
// Direct-mapped branch target buffer with 2-bit saturating direction
// counters and an integrated target adder.
// Ports:
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   flush              : invalidate every entry at the next edge
//   lk_valid, lk_pc    : lookup request; results registered one cycle later
//   lk_hit/lk_taken/lk_target : lookup result, all zero on miss or idle
//   rs_valid, rs_pc, rs_pc_next, rs_offset, rs_taken : branch resolution
//   rs_target, rs_target_valid : computed target one cycle after rs_valid
// Lookups read the arrays before the same edge's update/flush lands, so a
// same-cycle lookup always sees the pre-update contents.
module branch_target_buffer
  import branch_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int OFS_W   = 32,
  parameter int ENTRIES = 8,
  parameter int SHIFT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             lk_valid,
  input  logic [PC_W-1:0]  lk_pc,
  output logic             lk_hit,
  output logic             lk_taken,
  output logic [PC_W-1:0]  lk_target,
  input  logic             rs_valid,
  input  logic [PC_W-1:0]  rs_pc,
  input  logic [PC_W-1:0]  rs_pc_next,
  input  logic [OFS_W-1:0] rs_offset,
  input  logic             rs_taken,
  output logic [PC_W-1:0]  rs_target,
  output logic             rs_target_valid
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  // Entry storage in flops so reset can clear everything asynchronously.
  logic             valid_r [ENTRIES];
  logic [TAG_W-1:0] tag_r   [ENTRIES];
  logic [PC_W-1:0]  tgt_r   [ENTRIES];
  logic [1:0]       cnt_r   [ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX_W-1:0] rs_idx_s;
  logic [TAG_W-1:0] rs_tag_s;
  logic [PC_W-1:0]  calc_target_s;

  logic             lk_hit_s;
  logic             lk_taken_s;
  logic [PC_W-1:0]  lk_target_s;

  logic             rs_hit_s;
  logic             wr_en_s;
  logic [1:0]       wr_cnt_s;
  logic [PC_W-1:0]  wr_tgt_s;

  assign lk_idx_s = lk_pc[IDX_W-1:0];
  assign lk_tag_s = lk_pc[PC_W-1:IDX_W];
  assign rs_idx_s = rs_pc[IDX_W-1:0];
  assign rs_tag_s = rs_pc[PC_W-1:IDX_W];

  branch_target_adder #(
    .PC_W  (PC_W),
    .OFS_W (OFS_W),
    .SHIFT (SHIFT)
  ) u_adder (
    .pc_next (rs_pc_next),
    .offset  (rs_offset),
    .target  (calc_target_s)
  );

  // Lookup: tag compare against current (pre-update) array contents.
  always_comb begin
    lk_hit_s    = 1'b0;
    lk_taken_s  = 1'b0;
    lk_target_s = {PC_W{1'b0}};
    if (lk_valid && valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
      lk_hit_s    = 1'b1;
      lk_taken_s  = cnt_r[lk_idx_s][1];
      lk_target_s = tgt_r[lk_idx_s];
    end else begin
      lk_hit_s    = 1'b0;
    end
  end

  // Update decision: train on hit, allocate on taken miss; flush discards it.
  always_comb begin
    rs_hit_s = valid_r[rs_idx_s] && (tag_r[rs_idx_s] == rs_tag_s);
    wr_en_s  = 1'b0;
    wr_cnt_s = cnt_r[rs_idx_s];
    wr_tgt_s = tgt_r[rs_idx_s];
    if (rs_valid && !flush) begin
      if (rs_hit_s) begin
        wr_en_s  = 1'b1;
        wr_cnt_s = cnt_next(cnt_r[rs_idx_s], rs_taken);
        if (rs_taken) wr_tgt_s = calc_target_s;
        else          wr_tgt_s = tgt_r[rs_idx_s];
      end else if (rs_taken) begin
        // Allocation replaces whatever aliased entry lived at this index.
        wr_en_s  = 1'b1;
        wr_cnt_s = CNT_WT;
        wr_tgt_s = calc_target_s;
      end else begin
        wr_en_s  = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Entry array: async clear, flush clears valid bits, else single-entry write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= {TAG_W{1'b0}};
        tgt_r[i]   <= {PC_W{1'b0}};
        cnt_r[i]   <= CNT_SNT;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (wr_en_s) begin
      valid_r[rs_idx_s] <= 1'b1;
      tag_r[rs_idx_s]   <= rs_tag_s;
      tgt_r[rs_idx_s]   <= wr_tgt_s;
      cnt_r[rs_idx_s]   <= wr_cnt_s;
    end
  end

  // Registered lookup outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_hit    <= 1'b0;
      lk_taken  <= 1'b0;
      lk_target <= {PC_W{1'b0}};
    end else begin
      lk_hit    <= lk_hit_s;
      lk_taken  <= lk_taken_s;
      lk_target <= lk_target_s;
    end
  end

  // Registered resolve target; holds its value between pulses, even on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_target       <= {PC_W{1'b0}};
      rs_target_valid <= 1'b0;
    end else begin
      rs_target_valid <= rs_valid;
      if (rs_valid) rs_target <= calc_target_s;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer
// Self-checking bench for branch_target_buffer (PC_W=7, ENTRIES=8, SHIFT=0).
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model that keeps full PCs per slot and plain integer counters.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        lk_valid;
  logic [6:0]  lk_pc;
  logic        lk_hit;
  logic        lk_taken;
  logic [6:0]  lk_target;
  logic        rs_valid;
  logic [6:0]  rs_pc;
  logic [6:0]  rs_pc_next;
  logic [31:0] rs_offset;
  logic        rs_taken;
  logic [6:0]  rs_target;
  logic        rs_target_valid;

  int n_vec;
  int n_err;

  // Reference model: slot i holds the full PC it was allocated for.
  bit m_valid [8];
  int m_pc    [8];
  int m_tgt   [8];
  int m_cnt   [8];
  int exp_rs_target;

  branch_target_buffer #(
    .PC_W(7), .OFS_W(32), .ENTRIES(8), .SHIFT(0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .lk_valid        (lk_valid),
    .lk_pc           (lk_pc),
    .lk_hit          (lk_hit),
    .lk_taken        (lk_taken),
    .lk_target       (lk_target),
    .rs_valid        (rs_valid),
    .rs_pc           (rs_pc),
    .rs_pc_next      (rs_pc_next),
    .rs_offset       (rs_offset),
    .rs_taken        (rs_taken),
    .rs_target       (rs_target),
    .rs_target_valid (rs_target_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  // One clock of stimulus; expectations computed from the model state before
  // the edge, then the model is advanced and outputs checked after the edge.
  task automatic cycle(input bit lkv, input int lkpc, input bit rsv, input int rspc,
                       input int rsnext, input logic [31:0] rsofs, input bit rstk,
                       input bit fl);
    int li;
    int ri;
    bit e_hit;
    int e_tk;
    int e_tgt;
    int t;
    lk_valid   = lkv;
    lk_pc      = 7'(lkpc);
    rs_valid   = rsv;
    rs_pc      = 7'(rspc);
    rs_pc_next = 7'(rsnext);
    rs_offset  = rsofs;
    rs_taken   = rstk;
    flush      = fl;

    li    = lkpc % 8;
    e_hit = lkv && m_valid[li] && (m_pc[li] == lkpc);
    e_tk  = (e_hit && m_cnt[li] >= 2) ? 1 : 0;
    e_tgt = e_hit ? m_tgt[li] : 0;
    t     = int'((32'(rsnext) + rsofs) % 32'd128);
    if (rsv) exp_rs_target = t;

    if (fl) begin
      model_clear();
    end else if (rsv) begin
      ri = rspc % 8;
      if (m_valid[ri] && m_pc[ri] == rspc) begin
        if (rstk) begin
          m_cnt[ri] = (m_cnt[ri] < 3) ? m_cnt[ri] + 1 : 3;
          m_tgt[ri] = t;
        end else begin
          m_cnt[ri] = (m_cnt[ri] > 0) ? m_cnt[ri] - 1 : 0;
        end
      end else if (rstk) begin
        m_valid[ri] = 1'b1;
        m_pc[ri]    = rspc;
        m_tgt[ri]   = t;
        m_cnt[ri]   = 2;
      end
    end

    @(posedge clk);
    #1;
    check("lk_hit", 32'(lk_hit), 32'(e_hit));
    check("lk_taken", 32'(lk_taken), 32'(e_tk));
    check("lk_target", 32'(lk_target), 32'(e_tgt));
    check("rs_target_valid", 32'(rs_target_valid), 32'(rsv));
    check("rs_target", 32'(rs_target), 32'(exp_rs_target));
  endtask

  task automatic lookup(input int pc);
    cycle(1'b1, pc, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input int pc, input int nxt, input logic [31:0] ofs, input bit tk);
    cycle(1'b0, 0, 1'b1, pc, nxt, ofs, tk, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hit"}, 32'(lk_hit), 32'd0);
    check({tag, "_taken"}, 32'(lk_taken), 32'd0);
    check({tag, "_target"}, 32'(lk_target), 32'd0);
    check({tag, "_rs_target"}, 32'(rs_target), 32'd0);
    check({tag, "_rs_valid"}, 32'(rs_target_valid), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_rs_target = 0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
    end
    rst_n = 1'b0; flush = 1'b0; lk_valid = 1'b0; lk_pc = 7'd0;
    rs_valid = 1'b0; rs_pc = 7'd0; rs_pc_next = 7'd0; rs_offset = 32'd0; rs_taken = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Lookup after reset misses
    lookup(5);
    check("first_lookup_hit", 32'(lk_hit), 32'd0);

    // Basic resolve and lookup
    resolve(5, 6, 32'd3, 1'b1);
    check("target_9", 32'(rs_target), 32'd9);
    lookup(5);
    check("lookup5_hit", 32'(lk_hit), 32'd1);
    check("lookup5_target", 32'(lk_target), 32'd9);

    // Idle cycle after lookup returns zeros
    cycle(1'b0, 5, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0);
    check("idle_hit", 32'(lk_hit), 32'd0);

    // Target wrap
    resolve(40, 127, 32'd1, 1'b0);
    check("wrap_up", 32'(rs_target), 32'd0);
    resolve(41, 1, 32'hFFFF_FFFE, 1'b0);
    check("wrap_down", 32'(rs_target), 32'd127);

    // Counter saturation on pc 5 (currently weak taken)
    resolve(5, 6, 32'd3, 1'b0);
    resolve(5, 6, 32'd3, 1'b0);
    lookup(5);
    check("cnt_after_nt", 32'(lk_taken), 32'd0);
    for (int k = 0; k < 5; k++) resolve(5, 6, 32'd3, 1'b1);
    resolve(5, 6, 32'd3, 1'b0);
    lookup(5);
    check("cnt_sat_high", 32'(lk_taken), 32'd1);
    resolve(5, 6, 32'd3, 1'b0);
    lookup(5);
    check("cnt_weak_nt", 32'(lk_taken), 32'd0);
    for (int k = 0; k < 4; k++) resolve(5, 6, 32'd3, 1'b0);
    lookup(5);
    check("cnt_sat_low_hit", 32'(lk_hit), 32'd1);

    // Alias: pc 13 evicts pc 5
    resolve(5, 6, 32'd3, 1'b1);
    resolve(13, 10, 32'd10, 1'b1);
    lookup(5);
    check("alias_miss", 32'(lk_hit), 32'd0);
    lookup(13);
    check("alias_target", 32'(lk_target), 32'd20);

    // Same-cycle lookup and update returns old entry
    resolve(5, 6, 32'd3, 1'b1);
    cycle(1'b1, 5, 1'b1, 5, 30, 32'd0, 1'b1, 1'b0);
    check("rbw_target", 32'(lk_target), 32'd9);
    lookup(5);
    check("rbw_new_target", 32'(lk_target), 32'd30);

    // Flush with same-cycle update and lookup
    cycle(1'b1, 5, 1'b1, 2, 3, 32'd4, 1'b1, 1'b1);
    check("flush_lookup_pre", 32'(lk_hit), 32'd1);
    check("flush_rs_pulse", 32'(rs_target_valid), 32'd1);
    for (int p = 0; p < 16; p++) begin
      lookup(p);
      check("flush_miss", 32'(lk_hit), 32'd0);
    end

    // Reset asserted in the middle of an update cycle
    resolve(3, 1, 32'd1, 1'b1);
    lk_valid = 1'b1; lk_pc = 7'd3; rs_valid = 1'b1; rs_pc = 7'd3;
    rs_pc_next = 7'd10; rs_offset = 32'd1; rs_taken = 1'b1; flush = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_clear();
    exp_rs_target = 0;
    @(posedge clk);
    #1;
    check_all_zero("held_reset");
    rst_n = 1'b1;
    cycle(1'b1, 3, 1'b1, 3, 10, 32'd1, 1'b1, 1'b0);
    lookup(3);
    check("post_reset_update", 32'(lk_target), 32'd11);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 23)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 23)),
            int'($urandom_range(0, 127)), $urandom(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
